// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit logic unit with XOR accumulator and a valid/ready output stage.
// Optional handshake counter (txn_count) enabled by defining LOGIC_UNIT_PIPE_STATS_EN.
module logic_unit_pipe #(
  parameter int              WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic [WIDTH-1:0] acc
`ifdef LOGIC_UNIT_PIPE_STATS_EN
  ,
  output logic [15:0]      txn_count
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] result_reg, acc_reg, acc_next, acc_base, func;
  logic             zero_reg, parity_reg, accept;

  assign out_valid = (state_reg == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  // A same-cycle clear is applied before the ACC XOR.
  assign acc_base  = acc_clr ? ACC_INIT : acc_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic bit_val;
      always_comb begin
        case (op)
          3'd0:    bit_val = a[gi] & b[gi];
          3'd1:    bit_val = a[gi] | b[gi];
          3'd2:    bit_val = ~a[gi];
          3'd3:    bit_val = ~(a[gi] & b[gi]);
          3'd4:    bit_val = ~(a[gi] | b[gi]);
          3'd5:    bit_val = a[gi] ^ b[gi];
          3'd6:    bit_val = ~(a[gi] ^ b[gi]);
          default: bit_val = acc_base[gi] ^ a[gi];
        endcase
      end
      assign func[gi] = bit_val;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    case (state_reg)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (out_ready && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
    if (accept && op == 3'd7) acc_next = func;
    else if (acc_clr)         acc_next = ACC_INIT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= EMPTY;
      result_reg <= '0;
      zero_reg   <= 1'b1;
      parity_reg <= 1'b0;
      acc_reg    <= ACC_INIT;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      if (accept) begin
        result_reg <= func;
        zero_reg   <= ~|func;
        parity_reg <= ^func;
      end
    end
  end

  assign result = result_reg;
  assign zero   = zero_reg;
  assign parity = parity_reg;
  assign acc    = acc_reg;

`ifdef LOGIC_UNIT_PIPE_STATS_EN
  logic [15:0] txn_count_reg;

  // Counts output handshakes, saturating rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst)
      txn_count_reg <= 16'd0;
    else if (out_valid && out_ready && txn_count_reg != 16'hFFFF)
      txn_count_reg <= txn_count_reg + 16'd1;
  end

  assign txn_count = txn_count_reg;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe (WIDTH=8, ACC_INIT=0): directed plan plus random traffic
// against a cycle-level behavioural model of the output register and accumulator.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready, acc_clr;
  logic       in_ready, out_valid, zero, parity;
  logic [2:0] op;
  logic [7:0] a, b, result, acc;
`ifdef LOGIC_UNIT_PIPE_STATS_EN
  logic [15:0] txn_count;
`endif

  int checks = 0;
  int passed = 0;

  logic       m_valid;
  logic [7:0] m_result, m_acc;
  int         m_txn;
  logic       obs_in_ready, exp_in_ready;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .ACC_INIT(8'h00)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .parity(parity), .acc(acc)
`ifdef LOGIC_UNIT_PIPE_STATS_EN
    , .txn_count(txn_count)
`endif
  );

  function automatic logic [7:0] ref_func(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      3'd0:    return x & y;
      3'd1:    return x | y;
      3'd2:    return ~x;
      3'd3:    return ~(x & y);
      3'd4:    return ~(x | y);
      3'd5:    return x ^ y;
      default: return ~(x ^ y);
    endcase
  endfunction

  function automatic logic ref_parity(input logic [7:0] r);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(r[i]);
    return (ones % 2) == 1;
  endfunction

  // Drive one cycle of inputs, record in_ready before the edge, then advance the model.
  task automatic step(input logic v, input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                      input logic clr, input logic ordy, input logic r);
    logic [7:0] base;
    @(negedge clk);
    in_valid = v; op = o; a = aa; b = bb; acc_clr = clr; out_ready = ordy; rst = r;
    #1;
    exp_in_ready = !m_valid || ordy;
    obs_in_ready = in_ready;
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0; m_result = 8'h00; m_acc = 8'h00; m_txn = 0;
    end else begin
      if (m_valid && ordy && m_txn < 16'hFFFF) m_txn++;
      base = clr ? 8'h00 : m_acc;
      if (v && exp_in_ready) begin
        m_result = (o == 3'd7) ? (base ^ aa) : ref_func(o, aa, bb);
        m_valid  = 1'b1;
        if (o == 3'd7) m_acc = base ^ aa;
        else if (clr)  m_acc = 8'h00;
        $display("txn op=%0d a=%h b=%h clr=%0d -> %h", o, aa, bb, clr, m_result);
      end else begin
        if (ordy) m_valid = 1'b0;
        if (clr)  m_acc = 8'h00;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'd7, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    checks++; if (result !== 8'h00) $display("FAIL reset_result: got %h want 00", result); else passed++;
    checks++; if (zero !== 1'b1) $display("FAIL reset_zero: got %b want 1", zero); else passed++;
    checks++; if (parity !== 1'b0) $display("FAIL reset_parity: got %b want 0", parity); else passed++;
    checks++; if (acc !== 8'h00) $display("FAIL reset_acc: got %h want 00", acc); else passed++;
  endtask

  task automatic test_bitwise();
    logic [7:0] tab [7] = '{8'h30, 8'hFC, 8'h0F, 8'hCF, 8'h03, 8'hCC, 8'h33};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 3'(i), 8'hF0, 8'h3C, 1'b0, 1'b1, 1'b0);
      checks++; if (obs_in_ready !== 1'b1) $display("FAIL bitwise_in_ready op%0d: got %b want 1", i, obs_in_ready); else passed++;
      checks++; if (out_valid !== 1'b1) $display("FAIL bitwise_valid op%0d: got %b want 1", i, out_valid); else passed++;
      checks++; if (result !== tab[i]) $display("FAIL bitwise_result op%0d: got %h want %h", i, result, tab[i]); else passed++;
      checks++; if (zero !== (tab[i] == 8'h00)) $display("FAIL bitwise_zero op%0d: got %b", i, zero); else passed++;
      checks++; if (parity !== ref_parity(tab[i])) $display("FAIL bitwise_parity op%0d: got %b want %b", i, parity, ref_parity(tab[i])); else passed++;
    end
  endtask

  task automatic test_acc();
    logic [7:0] ins [3] = '{8'h11, 8'h22, 8'h44};
    logic [7:0] outs [3] = '{8'h11, 8'h33, 8'h77};
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd7, ins[i], 8'hFF, 1'b0, 1'b1, 1'b0);
      checks++; if (result !== outs[i]) $display("FAIL acc_result %0d: got %h want %h", i, result, outs[i]); else passed++;
      checks++; if (acc !== outs[i]) $display("FAIL acc_value %0d: got %h want %h", i, acc, outs[i]); else passed++;
    end
    step(1'b1, 3'd7, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0);
    checks++; if (result !== 8'h05) $display("FAIL acc_clr_result: got %h want 05", result); else passed++;
    checks++; if (acc !== 8'h05) $display("FAIL acc_clr_value: got %h want 05", acc); else passed++;
  endtask

  task automatic test_backpressure();
    step(1'b1, 3'd5, 8'hAA, 8'hAA, 1'b0, 1'b1, 1'b0);
    checks++; if (result !== 8'h00 || zero !== 1'b1) $display("FAIL bp_load: got %h/%b want 00/1", result, zero); else passed++;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd0, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0);
      checks++; if (obs_in_ready !== 1'b0) $display("FAIL bp_in_ready %0d: got %b want 0", i, obs_in_ready); else passed++;
      checks++; if (out_valid !== 1'b1 || result !== 8'h00) $display("FAIL bp_hold %0d: got %b/%h want 1/00", i, out_valid, result); else passed++;
    end
    step(1'b1, 3'd0, 8'hFF, 8'h0F, 1'b0, 1'b1, 1'b0);
    checks++; if (obs_in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", obs_in_ready); else passed++;
    checks++; if (out_valid !== 1'b1 || result !== 8'h0F) $display("FAIL bp_release_result: got %b/%h want 1/0f", out_valid, result); else passed++;
  endtask

  task automatic test_reset_mid();
    step(1'b1, 3'd7, 8'h77, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || acc !== 8'h77) $display("FAIL mid_setup: got %b/%h want 1/77", out_valid, acc); else passed++;
    step(1'b1, 3'd7, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", out_valid); else passed++;
    checks++; if (acc !== 8'h00 || result !== 8'h00) $display("FAIL mid_rst_regs: got %h/%h want 00/00", acc, result); else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 60) == 0));
      checks++; if (obs_in_ready !== exp_in_ready) $display("FAIL rand_in_ready %0d: got %b want %b", i, obs_in_ready, exp_in_ready); else passed++;
      checks++; if (out_valid !== m_valid) $display("FAIL rand_valid %0d: got %b want %b", i, out_valid, m_valid); else passed++;
      checks++; if (result !== m_result) $display("FAIL rand_result %0d: got %h want %h", i, result, m_result); else passed++;
      checks++; if (zero !== (m_result == 8'h00)) $display("FAIL rand_zero %0d: got %b result %h", i, zero, m_result); else passed++;
      checks++; if (parity !== ref_parity(m_result)) $display("FAIL rand_parity %0d: got %b want %b", i, parity, ref_parity(m_result)); else passed++;
      checks++; if (acc !== m_acc) $display("FAIL rand_acc %0d: got %h want %h", i, acc, m_acc); else passed++;
    end
  endtask

`ifdef LOGIC_UNIT_PIPE_STATS_EN
  task automatic test_stats();
    step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'd1, 8'h01, 8'h02, 1'b0, 1'b1, 1'b0);
    step(1'b1, 3'd1, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd1, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 3'd5, 8'(i), 8'h0F, 1'b1, 1'b1, 1'b0);
    checks++; if (txn_count !== 16'd5) $display("FAIL stats_count: got %0d want 5", txn_count); else passed++;
    @(negedge clk);
    force dut.txn_count_reg = 16'hFFFE;
    #1 release dut.txn_count_reg;
    m_txn = 16'hFFFE;
    for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    checks++; if (txn_count !== 16'hFFFF) $display("FAIL stats_saturate: got %h want ffff", txn_count); else passed++;
    checks++; if (int'(txn_count) !== m_txn) $display("FAIL stats_model: got %h want %h", txn_count, m_txn); else passed++;
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; acc_clr = 1'b0;
    op = 3'd0; a = 8'h00; b = 8'h00;
    m_valid = 1'b0; m_result = 8'h00; m_acc = 8'h00; m_txn = 0;
    test_reset();
    test_bitwise();
    test_acc();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef LOGIC_UNIT_PIPE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
